bit_reverse_reorder: RTL and testbench
======================================

BIT_REVERSE_REORDER -- requirements
Module: bit_reverse_reorder

Interface
REQ-001 Parameter: WIDTH, 32, packed sample width; real and imag each WIDTH bits.
REQ-002 Parameter: N, 256, frame length in samples; power of two, 4..1024; LOG2N = log2(N).
REQ-003 clock  input  1  master clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 input_en  input  1  input sample valid; the block accepts one sample per cycle while high.
REQ-006 input_real / input_imag  input  WIDTH  sample from the last SDF stage; frame order is bit-reversed.
REQ-007 output_en  output  1  output sample valid, registered.
REQ-008 output_real / output_imag  output  WIDTH  natural-order sample, registered.
REQ-009 output_last  output  1  high with the output sample at index N-1 only, registered.

Function
REQ-010 Storage: two banks (ping/pong), each N x 2*WIDTH. Bank write and bank read proceed concurrently.
REQ-011 Write counter wcnt (LOG2N bits) and write bank select wbank:
- On each cycle with input_en=1, write the sample to bank wbank at address bitrev(wcnt), then increment wcnt.
- When wcnt=N-1, wcnt wraps to 0 and wbank toggles.
REQ-012 input_en=0 mid-frame: wcnt holds and nothing is written. Gaps of any length are legal; frame content is unaffected.
REQ-013 Frame completion: the cycle that writes wcnt=N-1 arms a read of that bank. rcnt is loaded to 0, rbank is set to the completed bank, and reading becomes 1.
REQ-014 Read machine states:
- IDLE: wait for frame completion, then go to READ.
- READ: read address rcnt of rbank and increment rcnt every cycle, unconditionally, for N consecutive cycles.
- At rcnt=N-1: go to IDLE, unless a frame completes in that same cycle. In that case stay in READ with rcnt=0 and the new rbank (back-to-back frames).
REQ-015 Output register: each READ cycle loads output_real/imag with bank[rbank][rcnt], and loads output_en=1 and output_last=(rcnt==N-1). In IDLE, output_en=0, output_last=0, and the data registers hold their last value.
REQ-016 Latency: when the last sample of a frame is captured at edge E, natural-order sample n appears on the outputs after edge E+1+n. The valid burst is exactly N cycles, with no gaps.
REQ-017 Throughput: continuous input (input_en=1 forever) gives continuous output after the first frame.
- A frame can never be overwritten while it is being read, because a write frame takes at least N cycles.
- No backpressure exists.
REQ-018 Partial frames produce no output until they are completed.
REQ-019 Data is passed bit-exact; no arithmetic, scaling or sign change is applied.

Reset
REQ-020 While reset=1:
- wcnt=0, wbank=0, rcnt=0, rbank=0, read state=IDLE.
- output_en=0, output_last=0, output_real=0, output_imag=0.
REQ-021 Reset mid-operation discards any partial write frame and any in-progress read burst. Memory contents are not cleared and need not be.
REQ-022 The first sample with input_en=1 after reset is deasserted is frame index 0.

Verification (bench with N=16, WIDTH=32)
REQ-023 Single frame: input_real=k, input_imag=100+k for k=0..15 on consecutive cycles.
- output_en high for exactly 16 cycles, starting 1 cycle after the last input.
- output_real sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; imag = real + 100.
- output_last is high only on the final sample (15).
REQ-024 Back-to-back: three frames driven with input_en held high for 48 cycles.
- output_en stays high continuously for 48 cycles after the first latency.
- Each frame is reordered per REQ-023, with no cross-frame corruption.
REQ-025 Gapped input: one frame with input_en low for 3 cycles after sample 5 and low for 7 cycles after sample 11.
- Output is identical to REQ-023 and starts 1 cycle after sample 15 is captured.
REQ-026 Reset mid-frame: drive 9 samples, pulse reset, then drive a full frame with input_real=200+k.
- No output appears for the discarded samples.
- Output is 200+bitrev(n) only.
REQ-027 Overlap: a new frame starts the cycle after the previous frame completes.
- During the read burst, writes to the other bank do not disturb the output.
- At the boundary, output_last=1 is followed directly by output_en=1 with index 0 of the next frame.
REQ-028 Upstream pairing: a 4-stage SDF chain fed with an impulse at x[0]=1 produces all-equal outputs after reorder, compared against the reference FFT in natural order.

Source files
------------

// File: rtl/bit_reverse_reorder.sv
// Ping/pong reorder buffer that turns a bit-reversed SDF FFT frame into natural order.
// Frames are written at bit-reversed addresses and streamed out linearly from the completed bank.
module bit_reverse_reorder #(
    parameter int WIDTH = 32,
    parameter int N     = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real,
    input  logic [WIDTH-1:0] input_imag,
    output logic             output_en,
    output logic [WIDTH-1:0] output_real,
    output logic [WIDTH-1:0] output_imag,
    output logic             output_last
);

    localparam int              LOG2N    = $clog2(N);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    // Write side
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic [LOG2N-1:0] wr_addr;
    logic             frame_done;

    // Read side
    state_t           state_q, state_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic             rbank_q, rbank_d;

    // Output register
    logic             out_en_q, out_en_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_real_q, out_real_d;
    logic [WIDTH-1:0] out_imag_q, out_imag_d;

    // Both banks share one array; the top address bit is the bank select.
    logic [2*WIDTH-1:0] mem [2*N];
    logic [2*WIDTH-1:0] rd_word;

    // Bit-reversed write address: wire-swap of the write counter.
    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign wr_addr[gi] = wcnt_q[LOG2N-1-gi];
        end
    endgenerate

    assign frame_done = input_en && (wcnt_q == LAST_IDX);

    always_comb begin
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        if (input_en) begin
            wcnt_d = wcnt_q + LOG2N'(1);
        end
        if (frame_done) begin
            wbank_d = ~wbank_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt_q  <= '0;
            wbank_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            wbank_q <= wbank_d;
        end
    end

    // Memory is never reset; a discarded partial frame is simply overwritten later.
    always_ff @(posedge clock) begin
        if (input_en) begin
            mem[{wbank_q, wr_addr}] <= {input_real, input_imag};
        end
    end

    assign rd_word = mem[{rbank_q, rcnt_q}];

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        case (state_q)
            IDLE: begin
                if (frame_done) begin
                    state_d = READ;
                    rcnt_d  = '0;
                    rbank_d = wbank_q;
                end
            end
            READ: begin
                rcnt_d = rcnt_q + LOG2N'(1);
                if (rcnt_q == LAST_IDX) begin
                    // A frame finishing on the final read keeps the burst going.
                    if (frame_done) begin
                        rcnt_d  = '0;
                        rbank_d = wbank_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            rbank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            rbank_q <= rbank_d;
        end
    end

    always_comb begin
        out_en_d   = 1'b0;
        out_last_d = 1'b0;
        out_real_d = out_real_q;
        out_imag_d = out_imag_q;
        if (state_q == READ) begin
            out_en_d   = 1'b1;
            out_last_d = (rcnt_q == LAST_IDX);
            out_real_d = rd_word[2*WIDTH-1:WIDTH];
            out_imag_d = rd_word[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_en_q   <= 1'b0;
            out_last_q <= 1'b0;
            out_real_q <= '0;
            out_imag_q <= '0;
        end else begin
            out_en_q   <= out_en_d;
            out_last_q <= out_last_d;
            out_real_q <= out_real_d;
            out_imag_q <= out_imag_d;
        end
    end

    assign output_en   = out_en_q;
    assign output_last = out_last_q;
    assign output_real = out_real_q;
    assign output_imag = out_imag_q;

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Directed bench for bit_reverse_reorder with N=16, WIDTH=32.
// A monitor logs every valid output with its edge number; each test task checks the log.
module tb_bit_reverse_reorder;

    localparam int WIDTH = 32;
    localparam int N     = 16;

    logic             clock;
    logic             reset;
    logic             input_en;
    logic [WIDTH-1:0] input_real;
    logic [WIDTH-1:0] input_imag;
    logic             output_en;
    logic [WIDTH-1:0] output_real;
    logic [WIDTH-1:0] output_imag;
    logic             output_last;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Natural index n holds input sample bitrev4(n), worked out by hand.
    int exp_br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [WIDTH-1:0] obs_real [$];
    logic [WIDTH-1:0] obs_imag [$];
    logic             obs_last [$];
    int               obs_cyc  [$];

    bit_reverse_reorder #(.WIDTH(WIDTH), .N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .input_en    (input_en),
        .input_real  (input_real),
        .input_imag  (input_imag),
        .output_en   (output_en),
        .output_real (output_real),
        .output_imag (output_imag),
        .output_last (output_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        if (output_en === 1'b1) begin
            obs_real.push_back(output_real);
            obs_imag.push_back(output_imag);
            obs_last.push_back(output_last);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        obs_real.delete();
        obs_imag.delete();
        obs_last.delete();
        obs_cyc.delete();
    endtask

    // Drive one sample; edge_num is the rising edge that captures it.
    task automatic drive(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im, output int edge_num);
        @(negedge clock);
        input_en   = 1'b1;
        input_real = re;
        input_imag = im;
        edge_num   = cyc + 1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            input_en = 1'b0;
        end
    endtask

    // Bounded wait for count outputs, then a few more cycles to catch extras.
    task automatic wait_obs(input int count, input int budget);
        for (int i = 0; i < budget && obs_real.size() < count; i++) @(negedge clock);
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        input_en = 1'b0;
        input_real = '0;
        input_imag = '0;
        repeat (3) @(negedge clock);
        checks++; if (output_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", output_en); end
        checks++; if (output_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", output_last); end
        checks++; if (output_real !== '0) begin errors++; $display("FAIL reset_real got %0d want 0", output_real); end
        checks++; if (output_imag !== '0) begin errors++; $display("FAIL reset_imag got %0d want 0", output_imag); end
        reset = 1'b0;
        clear_log();
        idle_cycles(5);
        checks++; if (obs_real.size() != 0) begin errors++; $display("FAIL reset_idle_outputs got %0d want 0", obs_real.size()); end
    endtask

    task automatic test_single();
        int e;
        clear_log();
        for (int k = 0; k < N; k++) drive(32'(k), 32'(100 + k), e);
        idle_cycles(1);
        wait_obs(N, 40);
        checks++; if (obs_real.size() != N) begin errors++; $display("FAIL single_count got %0d want %0d", obs_real.size(), N); end
        for (int i = 0; i < N && i < obs_real.size(); i++) begin
            checks++; if (obs_real[i] !== 32'(exp_br[i])) begin errors++; $display("FAIL single_real[%0d] got %0d want %0d", i, obs_real[i], exp_br[i]); end
            checks++; if (obs_imag[i] !== 32'(100 + exp_br[i])) begin errors++; $display("FAIL single_imag[%0d] got %0d want %0d", i, obs_imag[i], 100 + exp_br[i]); end
            checks++; if (obs_last[i] !== (i == N - 1)) begin errors++; $display("FAIL single_last[%0d] got %b want %b", i, obs_last[i], (i == N - 1)); end
            checks++; if (obs_cyc[i] != e + 1 + i) begin errors++; $display("FAIL single_time[%0d] got %0d want %0d", i, obs_cyc[i], e + 1 + i); end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        int e0;
        clear_log();
        e0 = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                drive(32'(16 * f + k), 32'(500 + 16 * f + k), e);
                if (f == 0 && k == N - 1) e0 = e;
            end
        end
        idle_cycles(1);
        wait_obs(3 * N, 80);
        checks++; if (obs_real.size() != 3 * N) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_real.size(), 3 * N); end
        for (int i = 0; i < 3 * N && i < obs_real.size(); i++) begin
            checks++; if (obs_real[i] !== 32'(16 * (i / N) + exp_br[i % N])) begin errors++; $display("FAIL b2b_real[%0d] got %0d want %0d", i, obs_real[i], 16 * (i / N) + exp_br[i % N]); end
            checks++; if (obs_imag[i] !== 32'(500 + 16 * (i / N) + exp_br[i % N])) begin errors++; $display("FAIL b2b_imag[%0d] got %0d want %0d", i, obs_imag[i], 500 + 16 * (i / N) + exp_br[i % N]); end
            checks++; if (obs_last[i] !== ((i % N) == N - 1)) begin errors++; $display("FAIL b2b_last[%0d] got %b want %b", i, obs_last[i], ((i % N) == N - 1)); end
            checks++; if (obs_cyc[i] != e0 + 1 + i) begin errors++; $display("FAIL b2b_time[%0d] got %0d want %0d", i, obs_cyc[i], e0 + 1 + i); end
        end
    endtask

    task automatic test_gapped();
        int e;
        clear_log();
        for (int k = 0; k < N; k++) begin
            drive(32'(k), 32'(100 + k), e);
            if (k == 5) idle_cycles(3);
            if (k == 11) idle_cycles(7);
        end
        idle_cycles(1);
        wait_obs(N, 40);
        checks++; if (obs_real.size() != N) begin errors++; $display("FAIL gap_count got %0d want %0d", obs_real.size(), N); end
        for (int i = 0; i < N && i < obs_real.size(); i++) begin
            checks++; if (obs_real[i] !== 32'(exp_br[i])) begin errors++; $display("FAIL gap_real[%0d] got %0d want %0d", i, obs_real[i], exp_br[i]); end
            checks++; if (obs_imag[i] !== 32'(100 + exp_br[i])) begin errors++; $display("FAIL gap_imag[%0d] got %0d want %0d", i, obs_imag[i], 100 + exp_br[i]); end
            checks++; if (obs_last[i] !== (i == N - 1)) begin errors++; $display("FAIL gap_last[%0d] got %b want %b", i, obs_last[i], (i == N - 1)); end
            checks++; if (obs_cyc[i] != e + 1 + i) begin errors++; $display("FAIL gap_time[%0d] got %0d want %0d", i, obs_cyc[i], e + 1 + i); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int e;
        clear_log();
        for (int k = 0; k < 9; k++) drive(32'(900 + k), 32'(950 + k), e);
        @(negedge clock);
        input_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (output_en !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b want 0", output_en); end
        checks++; if (output_real !== '0) begin errors++; $display("FAIL rstmid_real got %0d want 0", output_real); end
        @(negedge clock);
        reset = 1'b0;
        idle_cycles(20);
        checks++; if (obs_real.size() != 0) begin errors++; $display("FAIL rstmid_partial_outputs got %0d want 0", obs_real.size()); end
        clear_log();
        for (int k = 0; k < N; k++) drive(32'(200 + k), 32'(300 + k), e);
        idle_cycles(1);
        wait_obs(N, 40);
        checks++; if (obs_real.size() != N) begin errors++; $display("FAIL rstmid_count got %0d want %0d", obs_real.size(), N); end
        for (int i = 0; i < N && i < obs_real.size(); i++) begin
            checks++; if (obs_real[i] !== 32'(200 + exp_br[i])) begin errors++; $display("FAIL rstmid_real[%0d] got %0d want %0d", i, obs_real[i], 200 + exp_br[i]); end
            checks++; if (obs_imag[i] !== 32'(300 + exp_br[i])) begin errors++; $display("FAIL rstmid_imag[%0d] got %0d want %0d", i, obs_imag[i], 300 + exp_br[i]); end
            checks++; if (obs_last[i] !== (i == N - 1)) begin errors++; $display("FAIL rstmid_last[%0d] got %b want %b", i, obs_last[i], (i == N - 1)); end
            checks++; if (obs_cyc[i] != e + 1 + i) begin errors++; $display("FAIL rstmid_time[%0d] got %0d want %0d", i, obs_cyc[i], e + 1 + i); end
        end
    endtask

    // Impulse into a 16-point FFT gives all-ones bins; in any order they stay all-ones.
    task automatic test_impulse_pairing();
        int e;
        clear_log();
        for (int k = 0; k < N; k++) drive(32'd1, 32'd0, e);
        idle_cycles(1);
        wait_obs(N, 40);
        checks++; if (obs_real.size() != N) begin errors++; $display("FAIL impulse_count got %0d want %0d", obs_real.size(), N); end
        for (int i = 0; i < N && i < obs_real.size(); i++) begin
            checks++; if (obs_real[i] !== 32'd1 || obs_imag[i] !== 32'd0) begin errors++; $display("FAIL impulse_bin[%0d] got %0d,%0d want 1,0", i, obs_real[i], obs_imag[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
        test_impulse_pairing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
